// File: rtl/router_pkt_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_tx_if
// Brief    : Request, payload and router-side signals of router_pkt_tx.
//            PARITY_CORRUPT_EN adds the corrupt_parity request qualifier.
// Revision : 1.0 - initial release
// ============================================================================
interface router_pkt_tx_if #(
   parameter int LEN_W  = 6,
   parameter int DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_addr;
   logic [LEN_W-1:0]  req_len;
   logic              req_err;
   logic              pl_valid;
   logic              pl_ready;
   logic [DATA_W-1:0] pl_data;
   logic              busy;
   logic              pkt_valid;
   logic [DATA_W-1:0] data_out;
   logic              tx_active;
   logic              tx_done;
`ifdef PARITY_CORRUPT_EN
   logic              corrupt_parity;
`endif

   // master: the packet client and router side; slave: the packet source itself
   modport master (
`ifdef PARITY_CORRUPT_EN
      output corrupt_parity,
`endif
      output req_valid, req_addr, req_len, pl_valid, pl_data, busy,
      input  req_ready, req_err, pl_ready, pkt_valid, data_out, tx_active, tx_done
   );

   modport slave (
`ifdef PARITY_CORRUPT_EN
      input  corrupt_parity,
`endif
      input  req_valid, req_addr, req_len, pl_valid, pl_data, busy,
      output req_ready, req_err, pl_ready, pkt_valid, data_out, tx_active, tx_done
   );
endinterface
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_tx
// Brief    : Store-and-forward packet source for the router input port:
//            header, payload, parity with busy back-pressure.
//            Option macro: PARITY_CORRUPT_EN (deliberately flips parity bit 0).
// Revision : 1.0 - initial release
// ============================================================================
module router_pkt_tx #(
   parameter int LEN_W      = 6,
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 2
) (
   input  wire logic       clock,
   input  wire logic       reset,
   router_pkt_tx_if.slave  bus
);
   localparam int c_DEPTH = (2 ** LEN_W) - 1;
   localparam int c_GAP_W = $clog2(GAP_CYCLES + 1);

   localparam logic [2:0] c_S_IDLE    = 3'd0;
   localparam logic [2:0] c_S_LOAD    = 3'd1;
   localparam logic [2:0] c_S_HEADER  = 3'd2;
   localparam logic [2:0] c_S_PAYLOAD = 3'd3;
   localparam logic [2:0] c_S_PARITY  = 3'd4;
   localparam logic [2:0] c_S_GAP     = 3'd5;

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_cnt;
   logic [DATA_W-1:0]  r_header;
   logic [DATA_W-1:0]  r_parity;
   logic [DATA_W-1:0]  r_data_out;
   logic               r_pkt_valid;
   logic               r_req_err;
   logic               r_tx_done;
   logic [c_GAP_W-1:0] r_gap_cnt;
   logic [DATA_W-1:0]  r_buf [0:c_DEPTH-1];

   logic               w_accept;
   logic               w_bad;
   logic               w_pl_fire;
   logic               w_consume;
   logic               w_last;
   logic               w_gap_done;
   logic [DATA_W-1:0]  w_header;
   logic [DATA_W-1:0]  w_corrupt_mask;
   logic               w_req_ready;
   logic               w_pl_ready;
   logic               w_tx_active;

   assign w_accept   = bus.req_valid && (r_state == c_S_IDLE);
   assign w_bad      = (bus.req_addr == 2'd3) || (bus.req_len == '0);
   assign w_pl_fire  = bus.pl_valid && (r_state == c_S_LOAD);
   assign w_consume  = !bus.busy;
   assign w_last     = (r_cnt == (r_len - LEN_W'(1)));
   assign w_gap_done = (r_gap_cnt == c_GAP_W'(GAP_CYCLES - 1));
   assign w_header   = DATA_W'({bus.req_len, bus.req_addr});

`ifdef PARITY_CORRUPT_EN
   // Folding the flip into the parity seed leaves the payload XOR untouched
   assign w_corrupt_mask = {{(DATA_W-1){1'b0}}, bus.corrupt_parity};
`else
   assign w_corrupt_mask = '0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= c_S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE:    if (w_accept && !w_bad)    w_state_nxt = c_S_LOAD;
         c_S_LOAD:    if (w_pl_fire && w_last)   w_state_nxt = c_S_HEADER;
         c_S_HEADER:  if (w_consume)             w_state_nxt = c_S_PAYLOAD;
         c_S_PAYLOAD: if (w_consume && w_last)   w_state_nxt = c_S_PARITY;
         c_S_PARITY:  if (w_consume)             w_state_nxt = c_S_GAP;
         c_S_GAP:     if (w_gap_done)            w_state_nxt = c_S_IDLE;
         default:                                w_state_nxt = c_S_IDLE;
      endcase
   end

   always_comb begin
      w_req_ready = 1'b0;
      w_pl_ready  = 1'b0;
      w_tx_active = 1'b1;
      case (r_state)
         c_S_IDLE: begin
            w_req_ready = 1'b1;
            w_tx_active = 1'b0;
         end
         c_S_LOAD: w_pl_ready = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_len       <= '0;
         r_cnt       <= '0;
         r_header    <= '0;
         r_parity    <= '0;
         r_data_out  <= '0;
         r_pkt_valid <= 1'b0;
         r_req_err   <= 1'b0;
         r_tx_done   <= 1'b0;
         r_gap_cnt   <= '0;
      end else begin
         r_req_err <= w_accept && w_bad;
         r_tx_done <= 1'b0;
         case (r_state)
            c_S_IDLE: begin
               if (w_accept && !w_bad) begin
                  r_len    <= bus.req_len;
                  r_header <= w_header;
                  r_parity <= w_header ^ w_corrupt_mask;
                  r_cnt    <= '0;
               end
            end
            c_S_LOAD: begin
               if (w_pl_fire) begin
                  r_parity <= r_parity ^ bus.pl_data;
                  if (w_last) begin
                     r_cnt       <= '0;
                     r_data_out  <= r_header;
                     r_pkt_valid <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + LEN_W'(1);
                  end
               end
            end
            c_S_HEADER: begin
               if (w_consume) begin
                  r_data_out <= r_buf[0];
                  r_cnt      <= '0;
               end
            end
            c_S_PAYLOAD: begin
               if (w_consume) begin
                  if (w_last) begin
                     r_data_out  <= r_parity;
                     r_pkt_valid <= 1'b0;
                  end else begin
                     r_cnt      <= r_cnt + LEN_W'(1);
                     r_data_out <= r_buf[r_cnt + LEN_W'(1)];
                  end
               end
            end
            c_S_PARITY: begin
               if (w_consume) begin
                  r_tx_done  <= 1'b1;
                  r_data_out <= '0;
                  r_gap_cnt  <= '0;
               end
            end
            c_S_GAP: r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
            default: ;
         endcase
      end
   end

   // Payload storage needs no reset; contents are always written before being read
   always_ff @(posedge clock) begin
      if (w_pl_fire) r_buf[r_cnt] <= bus.pl_data;
   end

   assign bus.req_ready = w_req_ready;
   assign bus.pl_ready  = w_pl_ready;
   assign bus.tx_active = w_tx_active;
   assign bus.req_err   = r_req_err;
   assign bus.tx_done   = r_tx_done;
   assign bus.pkt_valid = r_pkt_valid;
   assign bus.data_out  = r_data_out;
endmodule
`default_nettype wire
